tff_count_ctrl: RTL
===================

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, step period in sysclk cycles when the prescaler is compiled in; legal range 2..255.
REQ-002 SHALL have parameter AUTO_STOP, default 1, where 1 = halt at terminal count and 0 = wrap and keep running.
REQ-003 SHALL have port sysclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-005 SHALL have port start, input, 1, run request, level-sampled.
REQ-006 SHALL have port stop, input, 1, halt request, level-sampled.
REQ-007 SHALL have port dir, input, 1, count direction: 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1, load request.
REQ-009 SHALL have port load_val, input, 3, value to load into the counter.
REQ-010 SHALL have port q, input, 3, Q3..Q1 feedback from the external T-FF counter, with q[0] = Q1.
REQ-011 SHALL have port t, output, 3, toggle enables to the T-FFs; combinational from registered state, q, dir and tick.
REQ-012 SHALL have port busy, output, 1, high in RUN and LOAD.
REQ-013 SHALL have port done, output, 1, registered one-cycle terminal-count pulse.
REQ-014 SHALL have port state, output, 2, debug copy of the FSM state.

Function
REQ-015 SHALL implement FSM states IDLE=0, RUN=1, LOAD=2.
REQ-016 SHALL resolve input priority each cycle as rst > load > stop > start.
REQ-017 SHALL handle IDLE as:
- start=1 -> RUN;
- load=1 -> LOAD.
REQ-018 SHALL handle RUN as:
- stop=1 -> IDLE at the next edge, with t=0 in that cycle;
- load=1 -> LOAD;
- start ignored.
REQ-019 SHALL handle LOAD as:
- exactly one cycle long;
- drives t = q XOR load_val;
- always returns to IDLE;
- a load that is still asserted re-enters LOAD.
REQ-020 SHALL take one step in RUN on each cycle with tick=1:
- up: t = {q[1]&q[0], q[0], 1};
- down: t = {~q[1]&~q[0], ~q[0], 1}.
REQ-021 SHALL sample dir on every tick; a direction change mid-run takes effect on the next step.
REQ-022 SHALL define terminal count TC as q=7 when up and q=0 when down.
REQ-023 SHALL, when a tick occurs with q==TC and AUTO_STOP=1:
- drive t=0;
- pulse done for one cycle;
- go RUN -> IDLE.
REQ-024 SHALL, when a tick occurs with q==TC and AUTO_STOP=0:
- take a normal step (7->0 up, 0->7 down);
- pulse done;
- stay in RUN.
REQ-025 SHALL drive t=0 in IDLE, and in RUN on cycles with tick=0.
REQ-026 SHALL give stop priority over a same-cycle terminal-count tick: t=0, no done pulse.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set state=IDLE, done=0 and the prescale counter to 0.
REQ-028 SHALL hold t=0 while rst=1.
REQ-029 SHALL abort an in-progress RUN or LOAD on reset without a done pulse.
REQ-030 SHALL NOT reset the external counter; software issues load to clear it.

Configuration
REQ-031 SHALL implement the prescaler under macro TFF_CTRL_PRESCALE_EN, with behaviour:
- defined: tick=1 on one cycle in every PRESCALE cycles while in RUN;
  - the prescale counter counts 0..PRESCALE-1;
  - tick fires when it reaches PRESCALE-1;
  - the counter clears on entry to RUN;
- undefined: tick=1 on every RUN cycle, and PRESCALE is unused.
REQ-032 SHALL NOT gate load by tick under either configuration.

Structure
REQ-033 SHALL place the state encoding constants (IDLE, RUN, LOAD) and the terminal-count constants (TC_UP=3'd7, TC_DN=3'd0) in shared package tff_ctrl_pkg.
REQ-034 SHALL implement the prescaler as sub-module tff_prescaler with ports sysclk, rst, clr, en and tick.
REQ-035 SHALL keep the FSM and the t-decode in tff_count_ctrl.

Verification
REQ-036 SHALL pair the bench with a behavioural 3-bit T-FF counter and use a 20 ns clock (sysclk toggling every 10 ns).
REQ-037 SHALL cover reset: rst high for 1 cycle -> state=0, t=0, done=0, busy=0.
REQ-038 SHALL cover load: load=1 with load_val=5 in IDLE -> one LOAD cycle, then q=5 and state=IDLE.
REQ-039 SHALL cover up-count to halt, with q=5, dir=1, AUTO_STOP=1 and no prescaler:
- start -> q steps 6, 7;
- next cycle t=0 and done pulses once;
- state returns to IDLE.
REQ-040 SHALL cover down-count with wrap, with q=1, dir=0, AUTO_STOP=0:
- start -> q steps 0, 7, 6;
- done pulses on the 0->7 step;
- busy stays high.
REQ-041 SHALL cover the prescaler, with TFF_CTRL_PRESCALE_EN defined and PRESCALE=4:
- from q=0, start -> q increments exactly every 4 cycles;
- stop -> no further toggles.
REQ-042 SHALL cover collisions:
- stop and a terminal-count tick in the same cycle -> no done pulse, state=IDLE;
- rst during RUN -> state=IDLE and t=0 from the next edge.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared state encoding, terminal-count constants and T-FF step decode
// for the external 3-bit T flip-flop counter controller.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [2:0] TC_UP = 3'd7;
  localparam logic [2:0] TC_DN = 3'd0;

  // Synchronous binary counter built from T-FFs: each stage toggles when
  // all lower stages are 1 (up) or all lower stages are 0 (down).
  function automatic logic [2:0] step_toggles(input logic [2:0] q, input logic up);
    logic [2:0] tgl;
    if (up) tgl = {q[1] & q[0], q[0], 1'b1};
    else    tgl = {~q[1] & ~q[0], ~q[0], 1'b1};
    return tgl;
  endfunction

endpackage

// File: rtl/tff_prescaler.sv
// Step-rate prescaler: tick on one cycle in every PRESCALE enabled cycles.
// Only instantiated when TFF_CTRL_PRESCALE_EN is defined.
module tff_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(PRESCALE - 1);

  logic [7:0] cnt;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for an external 3-bit T-FF counter: run/stop/load FSM and
// toggle-enable decode. Define TFF_CTRL_PRESCALE_EN to slow steps to 1/PRESCALE.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | counter held, t=0, waiting for start or load
//   RUN   | one count step per tick in direction dir
//   LOAD  | single cycle, t = q ^ load_val so the counter takes load_val
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int AUTO_STOP = 1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic [2:0] q,
  output logic [2:0] t,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
    $error("tff_count_ctrl: PRESCALE must be in 2..255");
  end

  state_t     state_q, state_d;
  logic       done_q, done_d;
  logic [2:0] t_d;
  logic       tick;
  logic       at_tc;

`ifdef TFF_CTRL_PRESCALE_EN
  logic ps_clr;
  logic ps_en;

  // Restart the step period on every entry to RUN so the first step is a
  // full PRESCALE cycles after start.
  assign ps_clr = (state_q != RUN) && (state_d == RUN);
  assign ps_en  = (state_q == RUN);

  tff_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .sysclk(sysclk),
    .rst   (rst),
    .clr   (ps_clr),
    .en    (ps_en),
    .tick  (tick)
  );
`else
  assign tick = (state_q == RUN);
`endif

  assign at_tc = dir ? (q == TC_UP) : (q == TC_DN);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = 3'b000;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load)       state_d = LOAD;
        else if (stop)  state_d = IDLE;
        else if (start) state_d = RUN;
      end
      RUN: begin
        // Leaving RUN via load or stop takes no step and reports no done.
        if (load) begin
          state_d = LOAD;
        end else if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (at_tc && (AUTO_STOP != 0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            t_d    = step_toggles(q, dir);
            done_d = at_tc;
          end
        end
      end
      LOAD: begin
        t_d     = q ^ load_val;
        state_d = load ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) t_d = 3'b000;
  end

  assign t     = t_d;
  assign done  = done_q;
  assign busy  = (state_q == RUN) || (state_q == LOAD);
  assign state = state_q;

endmodule
